// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - 7-bit address I2C target with oversampled SCL/SDA and open-drain SDA drive
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_out_en,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic       rw_o,
    output logic       busy_o,
    output logic       addr_hit_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_WR_DATA   = 3'd3,
        S_WR_ACK    = 3'd4,
        S_RD_DATA   = 3'd5,
        S_RD_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } t_state;

    t_state r_state;
    t_state w_state_next;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    // Set once a byte's 8th bit (or a read ACK) is in; the following SCL fall acts on it.
    logic       r_byte_done;
    logic       r_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;
    logic       r_rw;
    logic       r_addr_hit;

    logic w_scl;
    logic w_sda;
    logic w_start;
    logic w_stop;
    logic w_rise;
    logic w_fall;
    logic w_last_bit;
    logic w_addr_match;
    logic w_oe_next;
    logic w_rx_valid_next;
    logic w_tx_req_next;
    logic w_addr_hit_next;

    assign w_scl   = r_scl_sync[SYNC_STAGES-1];
    assign w_sda   = r_sda_sync[SYNC_STAGES-1];
    assign w_start = r_sda_d & ~w_sda & w_scl;
    assign w_stop  = ~r_sda_d & w_sda & w_scl;
    // Bus conditions take precedence over any SCL edge seen in the same cycle.
    assign w_rise  = w_scl & ~r_scl_d & ~w_start & ~w_stop;
    assign w_fall  = ~w_scl & r_scl_d & ~w_start & ~w_stop;

    assign w_last_bit   = (r_bit_cnt == 3'd0);
    assign w_addr_match = (r_shift[6:0] == ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = S_IDLE;
        end else if (w_start) begin
            w_state_next = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_rise && w_last_bit && !w_addr_match) begin
                        w_state_next = S_WAIT_STOP;
                    end else if (w_fall && r_byte_done) begin
                        w_state_next = S_ADDR_ACK;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_fall) begin
                        w_state_next = r_rw ? S_RD_DATA : S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (w_fall && r_byte_done) begin
                        w_state_next = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (w_fall) begin
                        w_state_next = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_fall && r_byte_done) begin
                        w_state_next = S_RD_ACK;
                    end
                end
                S_RD_ACK: begin
                    if (w_rise && w_sda) begin
                        w_state_next = S_WAIT_STOP;
                    end else if (w_fall && r_byte_done) begin
                        w_state_next = S_RD_DATA;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_comb begin
        w_oe_next       = r_oe;
        w_rx_valid_next = 1'b0;
        w_tx_req_next   = 1'b0;
        w_addr_hit_next = 1'b0;
        if (w_stop || w_start) begin
            w_oe_next = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_rise && w_last_bit && w_addr_match) begin
                        w_addr_hit_next = 1'b1;
                        w_tx_req_next   = w_sda;
                    end else if (w_fall && r_byte_done) begin
                        w_oe_next = 1'b1;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_fall) begin
                        w_oe_next = r_rw ? ~tx_data_i[7] : 1'b0;
                    end
                end
                S_WR_DATA: begin
                    if (w_rise && w_last_bit) begin
                        w_rx_valid_next = 1'b1;
                    end else if (w_fall && r_byte_done) begin
                        w_oe_next = 1'b1;
                    end
                end
                S_WR_ACK: begin
                    if (w_fall) begin
                        w_oe_next = 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (w_fall) begin
                        w_oe_next = r_byte_done ? 1'b0 : ~r_shift[r_bit_cnt];
                    end
                end
                S_RD_ACK: begin
                    if (w_rise && !w_sda) begin
                        w_tx_req_next = 1'b1;
                    end else if (w_fall && r_byte_done) begin
                        w_oe_next = ~tx_data_i[7];
                    end
                end
                default: begin
                    w_oe_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd7;
            r_byte_done <= 1'b0;
            r_oe        <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_rw        <= 1'b0;
            r_addr_hit  <= 1'b0;
        end else begin
            r_oe       <= w_oe_next;
            r_rx_valid <= w_rx_valid_next;
            r_tx_req   <= w_tx_req_next;
            r_addr_hit <= w_addr_hit_next;
            if (w_stop) begin
                r_byte_done <= 1'b0;
            end else if (w_start) begin
                r_bit_cnt   <= 3'd7;
                r_byte_done <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            if (w_last_bit && w_addr_match) begin
                                r_byte_done <= 1'b1;
                                r_rw        <= w_sda;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_fall) begin
                            r_bit_cnt   <= 3'd7;
                            r_byte_done <= 1'b0;
                            if (r_rw) begin
                                r_shift <= tx_data_i;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (w_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            if (w_last_bit) begin
                                r_byte_done <= 1'b1;
                                r_rx_data   <= {r_shift[6:0], w_sda};
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (w_fall) begin
                            r_bit_cnt   <= 3'd7;
                            r_byte_done <= 1'b0;
                        end
                    end
                    S_RD_DATA: begin
                        if (w_rise) begin
                            if (w_last_bit) begin
                                r_byte_done <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end else if (w_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                        end
                    end
                    S_RD_ACK: begin
                        if (w_rise && !w_sda) begin
                            r_byte_done <= 1'b1;
                        end else if (w_fall && r_byte_done) begin
                            r_shift     <= tx_data_i;
                            r_bit_cnt   <= 3'd7;
                            r_byte_done <= 1'b0;
                        end
                    end
                    default: begin
                        r_byte_done <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_out_en = r_oe;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign tx_req_o   = r_tx_req;
    assign rw_o       = r_rw;
    assign addr_hit_o = r_addr_hit;
    assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed and randomized bus transactions checked against a transaction-level model
module tb_i2c_target;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_i;
    logic       ctl_sda;
    logic       bus_sda;
    logic       sda_out_en;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic [7:0] tx_data_i;
    logic       tx_req_o;
    logic       rw_o;
    logic       busy_o;
    logic       addr_hit_o;

    assign bus_sda = ctl_sda & ~sda_out_en;

    always #5 clk = ~clk;

    i2c_target #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_i),
        .sda_i      (bus_sda),
        .sda_out_en (sda_out_en),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .tx_data_i  (tx_data_i),
        .tx_req_o   (tx_req_o),
        .rw_o       (rw_o),
        .busy_o     (busy_o),
        .addr_hit_o (addr_hit_o)
    );

    int n_checks = 0;
    int n_err    = 0;

    int n_rxv = 0;
    int n_txr = 0;
    int n_hit = 0;
    int n_oe  = 0;
    logic [7:0] rx_log [$];

    always @(negedge clk) begin
        if (rx_valid_o) begin
            n_rxv++;
            rx_log.push_back(rx_data_o);
        end
        if (tx_req_o)   n_txr++;
        if (addr_hit_o) n_hit++;
        if (sda_out_en) n_oe++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_cond();
        wait_clk(Q);
        ctl_sda = 1'b0;
        wait_clk(Q);
        scl_i = 1'b0;
    endtask

    task automatic rstart_cond();
        wait_clk(Q);
        ctl_sda = 1'b1;
        wait_clk(Q);
        scl_i = 1'b1;
        wait_clk(Q);
        ctl_sda = 1'b0;
        wait_clk(Q);
        scl_i = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(Q);
        ctl_sda = 1'b0;
        wait_clk(Q);
        scl_i = 1'b1;
        wait_clk(Q);
        ctl_sda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        wait_clk(Q);
        ctl_sda = b;
        wait_clk(Q);
        scl_i = 1'b1;
        wait_clk(Q);
        s = bus_sda;
        wait_clk(Q);
        scl_i = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_bits(output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] got;
        logic [7:0] ab;
        logic [6:0] addr7;
        logic       is_rd;
        logic       hit;
        logic [7:0] data [3];
        int         n;
        int         c_rx, c_tx, c_hit, c_oe;

        reset = 1'b1; scl_i = 1'b1; ctl_sda = 1'b1; tx_data_i = 8'h00;
        wait_clk(4);
        check("rst_sda_out_en", 32'(sda_out_en), 0);
        check("rst_rx_data",    32'(rx_data_o), 0);
        check("rst_rx_valid",   32'(rx_valid_o), 0);
        check("rst_tx_req",     32'(tx_req_o), 0);
        check("rst_rw",         32'(rw_o), 0);
        check("rst_busy",       32'(busy_o), 0);
        check("rst_addr_hit",   32'(addr_hit_o), 0);
        reset = 1'b0;
        wait_clk(4);

        // Write 0xA0, 0x3C, 0xFF
        c_rx = n_rxv; c_hit = n_hit;
        start_cond();
        check("t1_busy_after_start", 32'(busy_o), 1);
        write_byte(8'hA0, ack);
        check("t1_addr_ack", 32'(ack), 1);
        check("t1_rw", 32'(rw_o), 0);
        write_byte(8'h3C, ack);
        check("t1_d0_ack", 32'(ack), 1);
        write_byte(8'hFF, ack);
        check("t1_d1_ack", 32'(ack), 1);
        stop_cond();
        wait_clk(4);
        check("t1_hits", 32'(n_hit - c_hit), 1);
        check("t1_rx_count", 32'(n_rxv - c_rx), 2);
        check("t1_rx0", 32'(rx_log[c_rx]), 'h3C);
        check("t1_rx1", 32'(rx_log[c_rx+1]), 'hFF);
        check("t1_busy_after_stop", 32'(busy_o), 0);

        // Read 0xA1: 0x5A (ACK), 0xC3 (NACK)
        c_tx = n_txr;
        tx_data_i = 8'h5A;
        start_cond();
        write_byte(8'hA1, ack);
        check("t2_addr_ack", 32'(ack), 1);
        check("t2_rw", 32'(rw_o), 1);
        read_bits(got);
        check("t2_byte0", 32'(got), 'h5A);
        tx_data_i = 8'hC3;
        clock_bit(1'b0, s);
        read_bits(got);
        check("t2_byte1", 32'(got), 'hC3);
        clock_bit(1'b1, s);
        wait_clk(Q);
        check("t2_sda_released", 32'(sda_out_en), 0);
        check("t2_busy_wait_stop", 32'(busy_o), 1);
        check("t2_tx_req_count", 32'(n_txr - c_tx), 2);
        stop_cond();
        wait_clk(4);
        check("t2_busy_after_stop", 32'(busy_o), 0);

        // Foreign address 0x9E
        c_rx = n_rxv; c_tx = n_txr; c_hit = n_hit; c_oe = n_oe;
        start_cond();
        write_byte(8'h9E, ack);
        check("t3_addr_nack", 32'(ack), 0);
        check("t3_busy", 32'(busy_o), 1);
        stop_cond();
        wait_clk(4);
        check("t3_no_drive", 32'(n_oe - c_oe), 0);
        check("t3_no_hit", 32'(n_hit - c_hit), 0);
        check("t3_no_rx", 32'(n_rxv - c_rx), 0);
        check("t3_no_tx_req", 32'(n_txr - c_tx), 0);
        check("t3_busy_after_stop", 32'(busy_o), 0);

        // Write 0x11, repeated START, read 0x77
        c_rx = n_rxv;
        tx_data_i = 8'h77;
        start_cond();
        write_byte(8'hA0, ack);
        check("t4_addr_w_ack", 32'(ack), 1);
        write_byte(8'h11, ack);
        check("t4_d_ack", 32'(ack), 1);
        check("t4_rx_data", 32'(rx_data_o), 'h11);
        check("t4_rx_log", 32'(rx_log[c_rx]), 'h11);
        wait_clk(Q);
        c_oe = n_oe;
        rstart_cond();
        check("t4_no_drive_rstart", 32'(n_oe - c_oe), 0);
        check("t4_busy_rstart", 32'(busy_o), 1);
        write_byte(8'hA1, ack);
        check("t4_addr_r_ack", 32'(ack), 1);
        check("t4_rw", 32'(rw_o), 1);
        read_bits(got);
        check("t4_rd_byte", 32'(got), 'h77);
        clock_bit(1'b1, s);
        stop_cond();
        wait_clk(4);

        // STOP after 4 data bits
        c_rx = n_rxv;
        start_cond();
        write_byte(8'hA0, ack);
        check("t5_addr_ack", 32'(ack), 1);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        stop_cond();
        wait_clk(4);
        check("t5_no_rx", 32'(n_rxv - c_rx), 0);
        check("t5_sda_released", 32'(sda_out_en), 0);
        check("t5_idle", 32'(busy_o), 0);

        // Reset while driving the address ACK of a read
        ab = 8'hA1;
        start_cond();
        for (int i = 7; i >= 0; i--) clock_bit(ab[i], s);
        for (int i = 0; i < 40 && !sda_out_en; i++) wait_clk(1);
        check("t6_ack_driving", 32'(sda_out_en), 1);
        check("t6_rw_before", 32'(rw_o), 1);
        reset = 1'b1;
        wait_clk(1);
        check("t6_sda_released", 32'(sda_out_en), 0);
        check("t6_rx_data", 32'(rx_data_o), 0);
        check("t6_rw", 32'(rw_o), 0);
        check("t6_busy", 32'(busy_o), 0);
        check("t6_pulses", 32'({rx_valid_o, tx_req_o, addr_hit_o}), 0);
        reset = 1'b0;
        scl_i = 1'b1;
        wait_clk(Q);
        ctl_sda = 1'b1;
        wait_clk(Q);
        check("t6_idle_after", 32'(busy_o), 0);

        // Randomized transactions against the transaction-level model
        for (int t = 0; t < 8; t++) begin
            is_rd = 1'($urandom_range(0, 1));
            hit   = ($urandom_range(0, 3) != 0);
            addr7 = hit ? 7'h50 : (7'h50 ^ 7'($urandom_range(1, 127)));
            n     = int'($urandom_range(1, 3));
            for (int i = 0; i < 3; i++) data[i] = 8'($urandom);
            c_rx = n_rxv; c_tx = n_txr; c_hit = n_hit; c_oe = n_oe;
            tx_data_i = data[0];
            start_cond();
            write_byte({addr7, is_rd}, ack);
            check("rnd_addr_ack", 32'(ack), 32'(hit));
            if (hit && !is_rd) begin
                for (int i = 0; i < n; i++) begin
                    write_byte(data[i], ack);
                    check("rnd_wr_ack", 32'(ack), 1);
                end
            end else if (hit && is_rd) begin
                for (int i = 0; i < n; i++) begin
                    read_bits(got);
                    check("rnd_rd_byte", 32'(got), 32'(data[i]));
                    if (i < n - 1) tx_data_i = data[i+1];
                    clock_bit((i < n - 1) ? 1'b0 : 1'b1, s);
                end
            end
            stop_cond();
            wait_clk(4);
            check("rnd_hits", 32'(n_hit - c_hit), 32'(hit));
            check("rnd_rx_count", 32'(n_rxv - c_rx), (hit && !is_rd) ? 32'(n) : 0);
            check("rnd_tx_req_count", 32'(n_txr - c_tx), (hit && is_rd) ? 32'(n) : 0);
            if (hit && !is_rd) begin
                for (int i = 0; i < n; i++) check("rnd_rx_byte", 32'(rx_log[c_rx+i]), 32'(data[i]));
            end
            if (!hit) check("rnd_no_drive", 32'(n_oe - c_oe), 0);
            check("rnd_busy_after_stop", 32'(busy_o), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
